// File: rtl/aes_round_ctrl.sv
// AES encryption-round sequencer: owns the cipher state register and walks the
// ARK/SBT/SRW/MXC stage units through NR rounds using their En/Ry handshake.
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 15
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [127:0] i_in_plain,
  output logic [127:0] o_out_cipher,
  output logic         o_done,
  output logic         o_busy,
  output logic         o_err,
  output logic [3:0]   o_round,
  output logic [127:0] o_stage_data,
  output logic         o_en_ark,
  output logic         o_en_sbt,
  output logic         o_en_srw,
  output logic         o_en_mxc,
  input  logic         i_ry_ark,
  input  logic         i_ry_sbt,
  input  logic         i_ry_srw,
  input  logic         i_ry_mxc,
  input  logic [127:0] i_out_ark,
  input  logic [127:0] i_out_sbt,
  input  logic [127:0] i_out_srw,
  input  logic [127:0] i_out_mxc,
  output logic [3:0]   o_key_idx
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ISS_ARK, S_WT_ARK, S_ISS_SBT, S_WT_SBT,
    S_ISS_SRW, S_WT_SRW, S_ISS_MXC, S_WT_MXC, S_DONE
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [127:0]   r_data, w_data_nxt;
  logic [127:0]   r_cipher, w_cipher_nxt;
  logic [3:0]     r_round, w_round_nxt;
  logic [TW-1:0]  r_tmo, w_tmo_nxt;
  logic           r_err, w_err_nxt;
  logic           w_ry;
  logic [127:0]   w_res;

  // Only the unit being awaited is looked at; stray Ry from others is dropped.
  always_comb begin
    w_ry  = 1'b0;
    w_res = '0;
    unique case (r_state)
      S_WT_ARK: begin w_ry = i_ry_ark; w_res = i_out_ark; end
      S_WT_SBT: begin w_ry = i_ry_sbt; w_res = i_out_sbt; end
      S_WT_SRW: begin w_ry = i_ry_srw; w_res = i_out_srw; end
      S_WT_MXC: begin w_ry = i_ry_mxc; w_res = i_out_mxc; end
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_cipher <= '0;
      r_round  <= '0;
      r_tmo    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_data   <= w_data_nxt;
      r_cipher <= w_cipher_nxt;
      r_round  <= w_round_nxt;
      r_tmo    <= w_tmo_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_data;
    w_cipher_nxt = r_cipher;
    w_round_nxt  = r_round;
    w_tmo_nxt    = r_tmo;
    w_err_nxt    = r_err;
    unique case (r_state)
      S_IDLE: if (i_start) begin
        w_data_nxt  = i_in_plain;
        w_round_nxt = '0;
        w_err_nxt   = 1'b0;
        w_state_nxt = S_ISS_ARK;
      end
      S_ISS_ARK: begin w_state_nxt = S_WT_ARK; w_tmo_nxt = '0; end
      S_ISS_SBT: begin w_state_nxt = S_WT_SBT; w_tmo_nxt = '0; end
      S_ISS_SRW: begin w_state_nxt = S_WT_SRW; w_tmo_nxt = '0; end
      S_ISS_MXC: begin w_state_nxt = S_WT_MXC; w_tmo_nxt = '0; end
      S_WT_ARK, S_WT_SBT, S_WT_SRW, S_WT_MXC: begin
        if (w_ry) begin
          w_data_nxt = w_res;
          unique case (r_state)
            S_WT_ARK: if (r_round == 4'(NR)) begin
              w_cipher_nxt = w_res;
              w_state_nxt  = S_DONE;
            end else begin
              w_round_nxt  = r_round + 4'd1;
              w_state_nxt  = S_ISS_SBT;
            end
            S_WT_SBT: w_state_nxt = S_ISS_SRW;
            S_WT_SRW: w_state_nxt = (r_round < 4'(NR)) ? S_ISS_MXC : S_ISS_ARK;
            default:  w_state_nxt = S_ISS_ARK;
          endcase
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle without Ry: abandon the run.
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_en_ark     = (r_state == S_ISS_ARK);
  assign o_en_sbt     = (r_state == S_ISS_SBT);
  assign o_en_srw     = (r_state == S_ISS_SRW);
  assign o_en_mxc     = (r_state == S_ISS_MXC);
  assign o_done       = (r_state == S_DONE);
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_err        = r_err;
  assign o_round      = r_round;
  assign o_key_idx    = r_round;
  assign o_stage_data = r_data;
  assign o_out_cipher = r_cipher;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES stage units with programmable Ry
// delay, a ciphertext scoreboard, and an enable-order monitor.
module tb_aes_round_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [127:0] i_plain = '0;
  logic [127:0] o_cipher, o_stage;
  logic         o_done, o_busy, o_err;
  logic [3:0]   o_round, o_key_idx;
  logic         o_en_ark, o_en_sbt, o_en_srw, o_en_mxc;
  logic [3:0]   u_ry = '0;
  logic [127:0] u_out [4];
  logic [3:0]   w_en;

  int n_vec = 0, n_err = 0;
  logic [127:0] sb_q [$];
  logic [7:0]   sbx [256];
  logic [127:0] rk [11];
  int dly_unit = -1, dly_round = 0, dly_cyc = 0;
  int stall_unit = -1, stall_round = 0;
  int u_cnt [4];
  bit u_pend [4];
  int ud;
  int mon_pos = 0, mon_u;
  bit prev_en = 0, prev_busy = 0;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_in_plain(i_plain),
    .o_out_cipher(o_cipher), .o_done(o_done), .o_busy(o_busy), .o_err(o_err),
    .o_round(o_round), .o_stage_data(o_stage),
    .o_en_ark(o_en_ark), .o_en_sbt(o_en_sbt), .o_en_srw(o_en_srw), .o_en_mxc(o_en_mxc),
    .i_ry_ark(u_ry[0]), .i_ry_sbt(u_ry[1]), .i_ry_srw(u_ry[2]), .i_ry_mxc(u_ry[3]),
    .i_out_ark(u_out[0]), .i_out_sbt(u_out[1]), .i_out_srw(u_out[2]), .i_out_mxc(u_out[3]),
    .o_key_idx(o_key_idx)
  );

  assign w_en = {o_en_mxc, o_en_srw, o_en_sbt, o_en_ark};

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbx[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];  a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];  a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk[0];
    for (int r = 1; r < 10; r++) s = mix_c(shift_r(sub_b(s))) ^ rk[r];
    return shift_r(sub_b(s)) ^ rk[10];
  endfunction

  function automatic logic [127:0] unit_fn(input int u, input logic [127:0] d, input logic [3:0] idx);
    case (u)
      0:       return d ^ rk[idx];
      1:       return sub_b(d);
      2:       return shift_r(d);
      default: return mix_c(d);
    endcase
  endfunction

  // Expected (unit, key index) of the p-th enable in a run.
  function automatic int exp_unit(input int p);
    if (p == 0) return 0;
    if (p <= 36) return ((p - 1) % 4) + 1 == 4 ? 0 : ((p - 1) % 4) + 1;
    if (p == 37) return 1;
    if (p == 38) return 2;
    if (p == 39) return 0;
    return 9;
  endfunction

  function automatic int exp_idx(input int p);
    if (p == 0) return 0;
    if (p <= 36) return (p - 1) / 4 + 1;
    return 10;
  endfunction

  // Stage units: result latched on En, Ry one cycle wide after the chosen delay.
  always @(posedge clk) begin
    for (int u = 0; u < 4; u++) begin
      u_ry[u] <= 1'b0;
      if (!rst_n) begin
        u_pend[u] <= 1'b0;
      end else if (w_en[u]) begin
        ud = (u == dly_unit && int'(o_round) == dly_round) ? dly_cyc :
             (u == stall_unit && int'(o_round) == stall_round) ? 100000 : 0;
        u_out[u] <= unit_fn(u, o_stage, o_key_idx);
        if (ud == 0) u_ry[u] <= 1'b1;
        else begin u_pend[u] <= 1'b1; u_cnt[u] <= ud - 1; end
      end else if (u_pend[u]) begin
        if (u_cnt[u] == 0) begin u_ry[u] <= 1'b1; u_pend[u] <= 1'b0; end
        else u_cnt[u] <= u_cnt[u] - 1;
      end
    end
  end

  // Enable-order monitor and ciphertext scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pos = 0; prev_en = 0; prev_busy = 0;
    end else begin
      if (o_busy && !prev_busy) mon_pos = 0;
      if (|w_en) begin
        mon_u = w_en[0] ? 0 : w_en[1] ? 1 : w_en[2] ? 2 : 3;
        chk("en_onehot", $countones(w_en), 1);
        chk("en_unit", mon_u, exp_unit(mon_pos));
        chk("en_keyidx", o_key_idx, exp_idx(mon_pos));
        chk("en_width", prev_en, 0);
        mon_pos++;
      end
      if (o_done) begin
        chk("en_total", mon_pos, 40);
        chk("sb_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) chk("cipher", o_cipher, sb_q.pop_front());
      end
      prev_en = |w_en;
      prev_busy = o_busy;
    end
  end

  // Called at a negedge; returns at a negedge with the DUT in IDLE.
  task automatic run(input logic [127:0] pt, input logic [127:0] exp_ct, input int exp_lat,
                     input bit exp_abort, input int inj_k, input int rst_k);
    int k = 0, k_en = -1;
    bit busy_ok = 1;
    logic [127:0] old_ct = o_cipher;
    i_start = 1'b1; i_plain = pt;
    sb_q.push_back(exp_ct);
    @(negedge clk);
    i_start = 1'b0;
    chk("accept_busy", o_busy, 1);
    chk("accept_err", o_err, 0);
    while (k <= 300) begin
      if (k == inj_k) begin i_start = 1'b1; i_plain = ~pt; end
      if (k == inj_k + 1) i_start = 1'b0;
      if (k == rst_k) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy_done_err", {o_busy, o_done, o_err}, 0);
        chk("rst_round", o_round, 0);
        chk("rst_stage", o_stage, 0);
        chk("rst_cipher", o_cipher, 0);
        chk("rst_en", w_en, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (o_en_srw && o_round == 4'd2 && k_en < 0) k_en = k;
      if (o_done || o_err) break;
      if (!o_busy) busy_ok = 0;
      @(negedge clk);
      k++;
    end
    if (exp_abort) begin
      chk("abort_err", o_err, 1);
      chk("abort_nodone", o_done, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_cycles", k - k_en, 16);
      chk("abort_cipher", o_cipher, old_ct);
      void'(sb_q.pop_front());
    end else begin
      chk("latency", k, exp_lat);
      chk("busy_held", busy_ok, 1);
      chk("done_busy", o_busy, 0);
      chk("run_err", o_err, 0);
      @(negedge clk);
      chk("done_pulse", o_done, 0);
    end
  endtask

  initial begin
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    logic [7:0] inv;
    logic [127:0] key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] p1, p2, p3;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbx[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    #2;
    chk("reset_busy_done_err", {o_busy, o_done, o_err}, 0);
    chk("reset_round", o_round, 0);
    chk("reset_cipher", o_cipher, 0);
    chk("reset_en", w_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32,
        80, 0, -10, -10);

    p1 = {$urandom, $urandom, $urandom, $urandom};
    dly_unit = 3; dly_round = 3; dly_cyc = 5;
    run(p1, aes(p1), 85, 0, -10, -10);
    dly_unit = -1;

    stall_unit = 2; stall_round = 2;
    run(p1 ^ 128'h1, 128'h0, 0, 1, -10, -10);
    stall_unit = -1;
    @(negedge clk);
    p2 = {$urandom, $urandom, $urandom, $urandom};
    run(p2, aes(p2), 80, 0, -10, -10);

    run(p1, aes(p1), 80, 0, 20, -10);
    run(p2 ^ p1, aes(p2 ^ p1), 80, 0, -10, -10);

    run(p2, 128'h0, 0, 0, -10, 37);
    @(negedge clk);
    p3 = {$urandom, $urandom, $urandom, $urandom};
    run(p3, aes(p3), 80, 0, -10, -10);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Encryption-round sequencer for the AES datapath.
- Owns the 128-bit cipher state register and drives it to the shared stage bus.
- Fires the AddRoundKey, SubBytes, ShiftRows and MixColumns units in FIPS-197 order over NR rounds, using each unit's En/Ry handshake, and returns the ciphertext with a Done pulse.
- Sits between the top-level host interface and the four stage units.

Parameters:
- NR, 10, number of rounds; round NR skips MixColumns.
- TIMEOUT, 15, maximum cycles spent waiting for any Ry before abort.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  begin encryption; sampled only in IDLE.
- In_Plain  in  128  plaintext; captured on the Start-accept edge.
- Out_Cipher  out  128  ciphertext; holds its value until the next Done.
- Done  out  1  one-cycle pulse; Out_Cipher is valid.
- Busy  out  1  high from the Start-accept edge until return to IDLE.
- Err  out  1  sticky timeout flag; cleared on the next accepted Start.
- Round  out  4  current round, 0..NR.
- Stage_Data  out  128  current state register; input bus to all units.
- En_ARK, En_SBT, En_SRW, En_MXC  out  1 each  unit enables.
- Ry_ARK, Ry_SBT, Ry_SRW, Ry_MXC  in  1 each  unit ready flags.
- Out_ARK, Out_SBT, Out_SRW, Out_MXC  in  128 each  unit results.
- Key_Idx  out  4  round-key index for the AddRoundKey unit; equals Round.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE; state register, Out_Cipher, Round, timeout counter = 0.
  - Done, Busy, Err, all En_* = 0.
- FSM states: IDLE, ISSUE_x / WAIT_x for x in {ARK, SBT, SRW, MXC}, DONE.
- En_x is a Moore decode: high only while in ISSUE_x, so every enable is exactly one cycle wide.
- IDLE:
  - Start=1 → load In_Plain, Round=0, Err=0, Busy=1, go to ISSUE_ARK.
  - Start in any other state is ignored; no queuing.
- ISSUE_x → WAIT_x unconditionally; timeout counter cleared.
- WAIT_x:
  - Ry_x=1 → capture Out_x into the state register and advance.
  - Ry_x=0 → increment timeout counter.
  - Counter reaches TIMEOUT → Err=1, Busy=0, go to IDLE, no Done, Out_Cipher unchanged.
- Advance order:
  - After ARK at Round=0: Round=1, go to SBT.
  - SBT → SRW.
  - SRW → MXC if Round<NR, else ARK.
  - MXC → ARK.
  - ARK with Round<NR: Round+1, go to SBT.
  - ARK with Round=NR: load Out_Cipher, go to DONE.
- DONE: Done=1 for one cycle, Busy=0, then IDLE. Start is not sampled in DONE.
- Ry_y from a unit not currently awaited is ignored; no capture occurs.
- Round counter never exceeds NR; no wrap.
- Latency with units that answer on the first edge: 2 cycles per stage.
  - Stage count: 1 + 4(NR-1) + 3 = 40 stages for NR=10.
  - Done is high in the 80th cycle after the Start-accept edge.
- Reset mid-operation: immediate return to reset values; a partial result is never presented.
- Stage_Data always equals the state register; it is stable during ISSUE and WAIT.

Test Plan:
- FIPS-197 App. B vector: In_Plain=3243f6a8885a308d313198a2e0370734 with the reference units → Out_Cipher=3925841d02dc09fbdc118597196a0b32, Done exactly once, 80 cycles after Start, Busy high throughout.
- Enable tracing: log En_*/Key_Idx across one run → order ARK(0), then SBT, SRW, MXC, ARK(r) for r=1..9, then SBT, SRW, ARK(10); no MXC in round 10; 40 enables total, each one cycle wide.
- Stretched ready: delay Ry_MXC by 5 cycles in round 3 → same ciphertext, Done at cycle 85, Err=0.
- Timeout: hold Ry_SRW=0 in round 2 → Err=1 after 15 wait cycles, Busy=0, no Done; next Start clears Err and completes correctly.
- Start while Busy: pulse Start again at cycle 20 with different plaintext → ignored, first ciphertext returned; a Start on the cycle after Done is accepted.
- Async reset: drop Rst_n at cycle 37 → all outputs 0 immediately, before the next Clk edge; after release, a fresh run produces the correct ciphertext.
